aes_msg_packer: RTL and testbench
=================================

# aes_msg_packer

Upstream feeder for the AES counter-mode core. It accepts a 32-bit Avalon-ST message stream and packs each group of four words into one 128-bit block. Each block is emitted as one beat on the core's `msg_in_st`-side stream, with sop, eop and a byte-count empty. It sustains one input word per cycle, applies backpressure from the core's ready, and flags malformed input packets.

## Interface
Parameters:
- IN_W, 32: input word width in bits.
- OUT_W, aes_model_pack::BLOCK_SIZE (128): output block width; must equal 4*IN_W.
- EMPTY_W, 7: output empty width, matching the core's empty field.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  IN_W  input word; first byte of the word in bits [31:24].
- in_valid  in  1  input word valid.
- in_sop  in  1  first word of a packet.
- in_eop  in  1  last word of a packet.
- in_empty  in  2  unused bytes at the LSB end of the eop word; ignored when in_eop=0.
- in_rdy  out  1  packer can accept a word this cycle.
- msg_out_st  avalon_st_if  —  block output to aes_counter_mode, with fields data[OUT_W], valid, sop, eop, empty[EMPTY_W] and rdy (input).
- protocol_err  out  1  one-cycle pulse when the input stream is malformed.

## Operation
- Accumulator: holds up to 4 words, with a word index idx in 0..3 and an in_pkt flag.
  - The word at idx=k lands in acc[127-32k -: 32]; the first word is MSB-aligned.
- Transfer: an input word is accepted when in_valid & in_rdy.
- Block completion: a block completes when the accepted word has idx=3 or in_eop=1. On completion:
  - out sop = 1 if the block contains the packet's sop word.
  - out eop = in_eop.
  - out empty = (3-idx)*4 + (in_eop ? in_empty : 0).
  - Bytes past the last valid byte are forced to 0.
  - idx returns to 0.
- Output register: one stage, with one pending-block slot behind it.
  - A completed block moves to the output register if it is empty or is draining this cycle (valid & rdy).
  - Otherwise the block is held in the accumulator and acc_full is set.
- in_rdy = !rst & !acc_full. in_rdy never depends on in_valid.
- Packet state: in_sop sets in_pkt; an accepted eop word clears it.
- Protocol errors (each pulses protocol_err for one cycle):
  - Word without sop while !in_pkt: the word is dropped; idx and output are unchanged.
  - in_sop while in_pkt:
    - The partial accumulator (idx>0) is discarded.
    - The sop word starts a fresh block at idx=0.
    - Earlier beats of the aborted packet already sent are not recalled.
  - sop and eop on the same word is legal: it produces a 1-word block with empty = 12 + in_empty.

## Timing
- Reset values: msg_out_st.valid=0, data=0, sop=0, eop=0, empty=0; protocol_err=0; in_rdy=0 while rst=1. Internal state: idx=0, in_pkt=0, acc_full=0.
- Reset mid-operation: all partial and pending blocks are discarded. in_rdy=1 on the first cycle after rst drops.
- Latency: a block that completes at edge N has msg_out_st.valid=1 after edge N (visible in cycle N+1).
- Throughput: with msg_out_st.rdy held at 1, 1 word/cycle with no bubbles, i.e. one block every 4 cycles.
- Backpressure:
  - While valid & !rdy, data/sop/eop/empty are held stable.
  - At most 4 more words are accepted (filling the accumulator), then in_rdy falls.
  - in_rdy rises the cycle after the output drains.
- Simultaneous drain and completion: the new block is loaded in the same edge, so valid stays high with no gap.

## Structure
- aes_model_pack: add WORDS_PER_BLOCK=4, BYTES_PER_WORD=4, and a typedef aes_block_t = logic[BLOCK_SIZE-1:0].
- Sub-module aes_st_out_reg: a single-entry Avalon-ST output register (load/hold/drain). It is reusable on the core's output side.
- The packer proper owns the accumulator, idx, in_pkt, acc_full and error detection.

## Test plan
- Single-block packet: 4 words 3243f6a8, 885a308d, 313198a2, e0370734 (sop on word 1, eop on word 4), rdy=1 → one beat with data 3243f6a8885a308d313198a2e0370734, sop=1, eop=1, empty=0, one cycle after word 4.
- Multi-block streaming: 12-word packet with in_valid held high → 3 beats on consecutive 4-cycle boundaries; sop only on beat 1, eop only on beat 3; in_rdy never low.
- Short tail: 6-word packet with in_empty=1 on word 6 → beat 2 has data {w5, w6 with its LSB byte zeroed, 64'h0}, eop=1, empty=9.
- Backpressure: rdy=0 for 10 cycles during continuous input → in_rdy falls after 8 accepted words; output data stays stable; no words lost after rdy=1.
- Errors:
  - Word without sop after reset → protocol_err=1 for 1 cycle, no output.
  - Second sop after 2 words → protocol_err, partial block dropped, next beat starts from the new sop word.
- Reset mid-packet: assert rst after 3 words → valid=0, in_rdy=0 during reset; a following clean 4-word packet is output correctly.

Source files
------------

// File: rtl/aes_model_pack.sv
// Shared AES model constants, block types and helpers.
// Carries the block geometry used by the message packer and the
// Avalon-ST payload struct handed between the packer and its output
// register.
package aes_model_pack;

   localparam int unsigned BLOCK_SIZE      = 128;
   localparam int unsigned WORDS_PER_BLOCK = 4;
   localparam int unsigned BYTES_PER_WORD  = 4;
   localparam int unsigned BYTES_PER_BLOCK = WORDS_PER_BLOCK * BYTES_PER_WORD;
   localparam int unsigned ST_EMPTY_W      = 7;
   localparam int unsigned IDX_W           = 2;

   typedef logic [BLOCK_SIZE-1:0] aes_block_t;

   // One Avalon-ST beat as stored in the output register.
   typedef struct packed {
      aes_block_t            data;
      logic                  sop;
      logic                  eop;
      logic [ST_EMPTY_W-1:0] empty;
   } st_beat_t;

   // Clear the n_empty least-significant bytes of a block.
   function automatic aes_block_t zero_tail(input aes_block_t blk,
                                            input logic [ST_EMPTY_W-1:0] n_empty);
      aes_block_t r_blk;
      r_blk = blk;
      for (int j = 0; j < int'(BYTES_PER_BLOCK); j++) begin
         if (j < int'(n_empty)) r_blk[8*j +: 8] = 8'h00;
      end
      return r_blk;
   endfunction

endpackage

// File: rtl/aes_msg_packer_if.sv
// Avalon-ST block stream between the message packer and the AES core.
// Fields: data[DATA_W], valid, sop, eop, empty[EMPTY_W] (source -> sink),
//         rdy (sink -> source).
// Modports: master = source side, slave = sink side.
interface avalon_st_if #(
   parameter int unsigned DATA_W  = 128,
   parameter int unsigned EMPTY_W = 7
) ();

   logic [DATA_W-1:0]  data;
   logic               valid;
   logic               sop;
   logic               eop;
   logic [EMPTY_W-1:0] empty;
   logic               rdy;

   modport master (
      output data,
      output valid,
      output sop,
      output eop,
      output empty,
      input  rdy
   );

   modport slave (
      input  data,
      input  valid,
      input  sop,
      input  eop,
      input  empty,
      output rdy
   );

endinterface

// File: rtl/aes_st_out_reg.sv
// Single-entry Avalon-ST output register (load / hold / drain).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i_load    - capture i_beat this cycle (caller only loads when o_free_c)
//   i_beat    - payload to capture
//   o_free_c  - register is empty or draining this cycle
//   st        - Avalon-ST source towards the sink
module aes_st_out_reg
   import aes_model_pack::*;
#(
   parameter int unsigned DATA_W  = BLOCK_SIZE,
   parameter int unsigned EMPTY_W = ST_EMPTY_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  st_beat_t    i_beat,
   output logic        o_free_c,
   avalon_st_if.master st
);

   logic     r_valid;
   st_beat_t r_beat;

   // Load wins over drain so back-to-back beats keep valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_beat  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_beat  <= i_beat;
      end else if (st.rdy) begin
         r_valid <= 1'b0;
      end
   end

   assign o_free_c = !r_valid || st.rdy;

   assign st.valid = r_valid;
   assign st.data  = DATA_W'(r_beat.data);
   assign st.sop   = r_beat.sop;
   assign st.eop   = r_beat.eop;
   assign st.empty = EMPTY_W'(r_beat.empty);

endmodule

// File: rtl/aes_msg_packer.sv
// Packs a 32-bit Avalon-ST message stream into 128-bit blocks for the
// AES counter-mode core, one block per output beat.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_data       - input word, first byte in the MSBs
//   in_valid      - input word valid
//   in_sop/in_eop - first/last word of a packet
//   in_empty      - unused LSB bytes of the eop word
//   in_rdy        - packer accepts a word this cycle
//   msg_out_st    - block stream towards the core
//   protocol_err  - one-cycle pulse on malformed input
module aes_msg_packer
   import aes_model_pack::*;
#(
   parameter int unsigned IN_W    = 32,
   parameter int unsigned OUT_W   = BLOCK_SIZE,
   parameter int unsigned EMPTY_W = ST_EMPTY_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] in_data,
   input  logic            in_valid,
   input  logic            in_sop,
   input  logic            in_eop,
   input  logic [1:0]      in_empty,
   output logic            in_rdy,
   avalon_st_if.master     msg_out_st,
   output logic            protocol_err
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

   // Accumulator and packet state; when r_acc_full the accumulator holds a
   // completed block waiting for the output register.
   logic [OUT_W-1:0]   r_acc;
   logic [IDX_W-1:0]   r_idx;
   logic               r_in_pkt;
   logic               r_acc_full;
   logic               r_blk_sop;
   logic               r_pend_eop;
   logic [EMPTY_W-1:0] r_pend_empty;
   logic               r_err;

   logic [OUT_W-1:0]   w_nxt_acc;
   logic [IDX_W-1:0]   w_nxt_idx;
   logic               w_nxt_in_pkt;
   logic               w_nxt_acc_full;
   logic               w_nxt_blk_sop;
   logic               w_nxt_pend_eop;
   logic [EMPTY_W-1:0] w_nxt_pend_empty;
   logic               w_nxt_err;

   logic               w_accept;
   logic               w_out_free;
   logic               w_load;
   st_beat_t           w_load_beat;
   logic [IDX_W-1:0]   w_pos;
   logic [OUT_W-1:0]   w_fill;
   logic [EMPTY_W-1:0] w_cmp_empty;
   logic [OUT_W-1:0]   w_cmp_data;

   assign in_rdy       = !rst && !r_acc_full;
   assign w_accept     = in_valid && in_rdy;
   assign protocol_err = r_err;

   // Accumulator state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc        <= '0;
         r_idx        <= '0;
         r_in_pkt     <= 1'b0;
         r_acc_full   <= 1'b0;
         r_blk_sop    <= 1'b0;
         r_pend_eop   <= 1'b0;
         r_pend_empty <= '0;
         r_err        <= 1'b0;
      end else begin
         r_acc        <= w_nxt_acc;
         r_idx        <= w_nxt_idx;
         r_in_pkt     <= w_nxt_in_pkt;
         r_acc_full   <= w_nxt_acc_full;
         r_blk_sop    <= w_nxt_blk_sop;
         r_pend_eop   <= w_nxt_pend_eop;
         r_pend_empty <= w_nxt_pend_empty;
         r_err        <= w_nxt_err;
      end
   end

   // Next-state: word placement, block completion, hand-off and error checks.
   always_comb begin
      w_nxt_acc        = r_acc;
      w_nxt_idx        = r_idx;
      w_nxt_in_pkt     = r_in_pkt;
      w_nxt_acc_full   = r_acc_full;
      w_nxt_blk_sop    = r_blk_sop;
      w_nxt_pend_eop   = r_pend_eop;
      w_nxt_pend_empty = r_pend_empty;
      w_nxt_err        = 1'b0;
      w_load           = 1'b0;

      // A sop word always restarts the block, discarding any partial one.
      w_pos  = in_sop ? '0 : r_idx;
      w_fill = in_sop ? '0 : r_acc;
      for (int k = 0; k < int'(WORDS_PER_BLOCK); k++) begin
         if (w_pos == IDX_W'(k)) w_fill[OUT_W-1-IN_W*k -: IN_W] = in_data;
      end

      w_cmp_empty = EMPTY_W'({LAST_IDX - w_pos, 2'b00})
                  + EMPTY_W'(in_eop ? in_empty : 2'd0);
      w_cmp_data  = OUT_W'(zero_tail(aes_block_t'(w_fill), ST_EMPTY_W'(w_cmp_empty)));

      w_load_beat.data  = aes_block_t'(r_acc);
      w_load_beat.sop   = r_blk_sop;
      w_load_beat.eop   = r_pend_eop;
      w_load_beat.empty = ST_EMPTY_W'(r_pend_empty);

      if (r_acc_full) begin
         // Pending block leaves as soon as the output register frees up.
         if (w_out_free) begin
            w_load         = 1'b1;
            w_nxt_acc_full = 1'b0;
            w_nxt_acc      = '0;
            w_nxt_blk_sop  = 1'b0;
         end
      end else if (w_accept) begin
         if (!r_in_pkt && !in_sop) begin
            w_nxt_err = 1'b1;
         end else begin
            w_nxt_err     = in_sop && r_in_pkt;
            w_nxt_in_pkt  = !in_eop;
            w_nxt_blk_sop = in_sop || r_blk_sop;
            if (w_pos == LAST_IDX || in_eop) begin
               w_nxt_idx         = '0;
               w_load_beat.data  = aes_block_t'(w_cmp_data);
               w_load_beat.sop   = in_sop || r_blk_sop;
               w_load_beat.eop   = in_eop;
               w_load_beat.empty = ST_EMPTY_W'(w_cmp_empty);
               if (w_out_free) begin
                  w_load        = 1'b1;
                  w_nxt_acc     = '0;
                  w_nxt_blk_sop = 1'b0;
               end else begin
                  w_nxt_acc        = w_cmp_data;
                  w_nxt_pend_eop   = in_eop;
                  w_nxt_pend_empty = w_cmp_empty;
                  w_nxt_acc_full   = 1'b1;
               end
            end else begin
               w_nxt_acc = w_fill;
               w_nxt_idx = w_pos + IDX_W'(1);
            end
         end
      end
   end

   aes_st_out_reg #(
      .DATA_W  (OUT_W),
      .EMPTY_W (EMPTY_W)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .i_beat   (w_load_beat),
      .o_free_c (w_out_free),
      .st       (msg_out_st)
   );

endmodule

// File: tb/tb_aes_msg_packer.sv
// Scoreboard bench for aes_msg_packer.
module tb_aes_msg_packer;

   typedef struct {
      logic [127:0] data;
      logic         sop;
      logic         eop;
      logic [6:0]   empty;
   } beat_t;

   typedef logic [31:0] word_q_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic [1:0]  in_empty = '0;
   logic        in_rdy;
   logic        protocol_err;

   avalon_st_if #(.DATA_W(128), .EMPTY_W(7)) msg_if ();

   aes_msg_packer dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_sop       (in_sop),
      .in_eop       (in_eop),
      .in_empty     (in_empty),
      .in_rdy       (in_rdy),
      .msg_out_st   (msg_if),
      .protocol_err (protocol_err)
   );

   always #5 clk = ~clk;

   int      n_vec = 0;
   int      n_err = 0;
   int      cyc = 0;
   int      n_acc = 0;
   int      last_acc_cyc = 0;
   int      err_seen = 0;
   int      err_exp = 0;
   int      rdy_low = 0;
   bit      watch_rdy = 0;
   bit      stall_prev = 0;
   beat_t   held;
   beat_t   mon_e;
   beat_t   exp_q[$];
   int      beat_cyc[$];
   word_q_t pkt_w;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: scoreboard pop, hold-stability, pulse counters.
   always @(negedge clk) begin
      if (msg_if.valid && msg_if.rdy) begin
         beat_cyc.push_back(cyc);
         chk_eq("beat_expected", 128'(exp_q.size() != 0), 128'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk_eq("beat_data", msg_if.data, mon_e.data);
            chk_eq("beat_sop", 128'(msg_if.sop), 128'(mon_e.sop));
            chk_eq("beat_eop", 128'(msg_if.eop), 128'(mon_e.eop));
            chk_eq("beat_empty", 128'(msg_if.empty), 128'(mon_e.empty));
         end
      end
      if (stall_prev) begin
         chk_eq("hold_valid", 128'(msg_if.valid), 128'd1);
         chk_eq("hold_data", msg_if.data, held.data);
         chk_eq("hold_sop", 128'(msg_if.sop), 128'(held.sop));
         chk_eq("hold_eop", 128'(msg_if.eop), 128'(held.eop));
         chk_eq("hold_empty", 128'(msg_if.empty), 128'(held.empty));
      end
      stall_prev = msg_if.valid && !msg_if.rdy;
      held.data  = msg_if.data;
      held.sop   = msg_if.sop;
      held.eop   = msg_if.eop;
      held.empty = msg_if.empty;
      if (protocol_err) err_seen++;
      if (watch_rdy && !in_rdy) rdy_low++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one word until accepted; returns 1 ns after the accepting edge.
   task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
      bit got;
      int n;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      in_empty = emp;
      in_valid = 1'b1;
      got = 0;
      n   = 0;
      while (!got && n < 200) begin
         @(negedge clk);
         got = in_rdy;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      if (got) begin
         n_acc++;
         last_acc_cyc = cyc;
      end else begin
         chk_eq("send_timeout", 128'(got), 128'd1);
      end
   endtask

   task automatic send_pkt(input word_q_t w, input logic [1:0] last_emp);
      for (int i = 0; i < w.size(); i++)
         send(w[i], i == 0, i == w.size() - 1, (i == w.size() - 1) ? last_emp : 2'd0);
   endtask

   // Reference packing: 4 words per beat, MSB first, tail bytes zeroed.
   task automatic push_pkt(input word_q_t w, input logic [1:0] last_emp);
      int    nb;
      int    cnt;
      beat_t b;
      nb = (w.size() + 3) / 4;
      for (int bi = 0; bi < nb; bi++) begin
         b.data = '0;
         cnt = 0;
         for (int k = 0; k < 4; k++) begin
            if (4*bi + k < w.size()) begin
               b.data[127-32*k -: 32] = w[4*bi + k];
               cnt++;
            end
         end
         b.sop   = (bi == 0);
         b.eop   = (bi == nb - 1);
         b.empty = 7'((4 - cnt) * 4 + ((bi == nb - 1) ? int'(last_emp) : 0));
         for (int j = 0; j < 16; j++)
            if (j < int'(b.empty)) b.data[8*j +: 8] = 8'h00;
         exp_q.push_back(b);
      end
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk_eq({tag, "_drain"}, 128'(exp_q.size()), 128'd0);
      step(2);
   endtask

   beat_t b;

   initial begin
      msg_if.rdy = 1'b1;

      // Reset state
      step(3);
      chk_eq("rst_valid", 128'(msg_if.valid), 128'd0);
      chk_eq("rst_data", msg_if.data, 128'd0);
      chk_eq("rst_sop", 128'(msg_if.sop), 128'd0);
      chk_eq("rst_eop", 128'(msg_if.eop), 128'd0);
      chk_eq("rst_empty", 128'(msg_if.empty), 128'd0);
      chk_eq("rst_err", 128'(protocol_err), 128'd0);
      chk_eq("rst_in_rdy", 128'(in_rdy), 128'd0);
      rst = 1'b0;
      step(1);
      chk_eq("post_rst_in_rdy", 128'(in_rdy), 128'd1);

      // Word without sop after reset: dropped, one-cycle error pulse
      beat_cyc.delete();
      send(32'hdeadbeef, 1'b0, 1'b0, 2'd0);
      err_exp++;
      @(negedge clk);
      chk_eq("nosop_err_pulse", 128'(protocol_err), 128'd1);
      @(negedge clk);
      chk_eq("nosop_err_clear", 128'(protocol_err), 128'd0);
      step(4);
      chk_eq("nosop_no_beat", 128'(beat_cyc.size()), 128'd0);

      // Single-block packet
      b.data = 128'h3243f6a8885a308d313198a2e0370734;
      b.sop = 1'b1; b.eop = 1'b1; b.empty = 7'd0;
      exp_q.push_back(b);
      beat_cyc.delete();
      pkt_w = '{32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734};
      send_pkt(pkt_w, 2'd0);
      wait_drain("single");
      chk_eq("single_nbeats", 128'(beat_cyc.size()), 128'd1);
      if (beat_cyc.size() > 0)
         chk_eq("single_latency", 128'(beat_cyc[0]), 128'(last_acc_cyc));

      // Multi-block streaming, 12 words back to back
      pkt_w.delete();
      for (int i = 0; i < 12; i++) pkt_w.push_back(32'h10203040 + 32'(i) * 32'h01010101);
      push_pkt(pkt_w, 2'd0);
      beat_cyc.delete();
      rdy_low = 0;
      watch_rdy = 1;
      send_pkt(pkt_w, 2'd0);
      watch_rdy = 0;
      wait_drain("multi");
      chk_eq("multi_rdy_low", 128'(rdy_low), 128'd0);
      chk_eq("multi_nbeats", 128'(beat_cyc.size()), 128'd3);
      if (beat_cyc.size() >= 3) begin
         chk_eq("multi_gap1", 128'(beat_cyc[1] - beat_cyc[0]), 128'd4);
         chk_eq("multi_gap2", 128'(beat_cyc[2] - beat_cyc[1]), 128'd4);
      end

      // Short tail: 6 words, last with one empty byte
      pkt_w = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                32'ha1a2a3a4, 32'hb1b2b3b4};
      b.data = 128'h00112233445566778899aabbccddeeff;
      b.sop = 1'b1; b.eop = 1'b0; b.empty = 7'd0;
      exp_q.push_back(b);
      b.data = {32'ha1a2a3a4, 32'hb1b2b300, 64'h0};
      b.sop = 1'b0; b.eop = 1'b1; b.empty = 7'd9;
      exp_q.push_back(b);
      send_pkt(pkt_w, 2'd1);
      wait_drain("tail");

      // sop and eop on the same word
      pkt_w = '{32'hcafef00d};
      push_pkt(pkt_w, 2'd2);
      send_pkt(pkt_w, 2'd2);
      wait_drain("one_word");

      // Second sop after two words: partial block discarded
      send(32'h11111111, 1'b1, 1'b0, 2'd0);
      send(32'h22222222, 1'b0, 1'b0, 2'd0);
      pkt_w = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h99999999};
      push_pkt(pkt_w, 2'd3);
      err_exp++;
      send_pkt(pkt_w, 2'd3);
      wait_drain("resop");
      chk_eq("resop_err_cnt", 128'(err_seen), 128'(err_exp));

      // Backpressure: rdy low for 10 cycles during continuous input
      pkt_w.delete();
      for (int i = 0; i < 12; i++) pkt_w.push_back(32'hf0e1d2c3 ^ (32'(i) << 8));
      push_pkt(pkt_w, 2'd0);
      msg_if.rdy = 1'b0;
      n_acc = 0;
      fork
         send_pkt(pkt_w, 2'd0);
      join_none
      repeat (10) @(posedge clk);
      #2;
      chk_eq("bp_accepted", 128'(n_acc), 128'd8);
      chk_eq("bp_in_rdy_low", 128'(in_rdy), 128'd0);
      msg_if.rdy = 1'b1;
      @(negedge clk);
      chk_eq("bp_in_rdy_before_drain", 128'(in_rdy), 128'd0);
      @(negedge clk);
      chk_eq("bp_in_rdy_after_drain", 128'(in_rdy), 128'd1);
      wait fork;
      wait_drain("bp");
      chk_eq("bp_total", 128'(n_acc), 128'd12);

      // Reset mid-packet
      send(32'h01020304, 1'b1, 1'b0, 2'd0);
      send(32'h05060708, 1'b0, 1'b0, 2'd0);
      send(32'h090a0b0c, 1'b0, 1'b0, 2'd0);
      rst = 1'b1;
      step(1);
      chk_eq("midrst_valid", 128'(msg_if.valid), 128'd0);
      chk_eq("midrst_in_rdy", 128'(in_rdy), 128'd0);
      step(1);
      rst = 1'b0;
      step(1);
      chk_eq("midrst_in_rdy_up", 128'(in_rdy), 128'd1);
      pkt_w = '{32'ha0a1a2a3, 32'hb0b1b2b3, 32'hc0c1c2c3, 32'hd0d1d2d3};
      push_pkt(pkt_w, 2'd0);
      send_pkt(pkt_w, 2'd0);
      wait_drain("midrst");

      step(3);
      chk_eq("err_pulses", 128'(err_seen), 128'(err_exp));
      chk_eq("queue_empty", 128'(exp_q.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
